instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage sitting directly upstream of the processor core (datapath + control). Keeps the program counter, issues word reads to instruction memory over a req/ack handshake with at most one request outstanding, and buffers returned words in a small FIFO. The core pops one instruction per cycle with a valid/ready handshake. A branch redirect from the core flushes the buffer and restarts fetch at the target.

## Interface
Parameters:
- `ADDR_W`, 32, PC/address width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `RESET_PC`, 0, fetch address after reset; word-aligned

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `reset` in 1: synchronous, active-high
- `imem_req` out 1: read request; held high until `imem_ack`
- `imem_addr` out ADDR_W: word address; stable while `imem_req` is high
- `imem_ack` in 1: read complete; `imem_rdata` valid this cycle
- `imem_rdata` in 32: instruction word
- `instr_valid` out 1: FIFO head valid
- `instr_ready` in 1: core accepts head when high with `instr_valid`
- `instr` out 32: head instruction
- `opcode` out 6: `instr[31:26]`
- `func` out 11: `instr[10:0]`
- `pc_out` out ADDR_W: address of head instruction
- `redirect` in 1: flush and restart fetch
- `redirect_pc` in ADDR_W: new fetch address; bits [1:0] forced to 0

## Operation
- FIFO entries hold {pc, word}. Push on accepted ack; pop on `instr_valid && instr_ready`. Count tracks occupancy 0..DEPTH.
- `fetch_pc` increments by 4 after each accepted ack, wrapping modulo 2^ADDR_W.
- FSM states:
  - IDLE: `imem_req`=0. Go to BUSY when the count after this cycle's push/pop is < DEPTH.
  - BUSY: `imem_req`=1, `imem_addr`=`fetch_pc`. On ack, push the word. Stay in BUSY (next address, back-to-back) if post-push count < DEPTH, otherwise go to IDLE.
  - DROP: `imem_req`=1 on the stale address. On ack, discard the data, then go to BUSY at the redirected PC.
- Redirect, all states: FIFO cleared the same edge; `fetch_pc` <= `redirect_pc & ~3`. A same-cycle pop is ignored.
  - IDLE: go to BUSY.
  - BUSY without ack: go to DROP, because the address must stay stable.
  - BUSY with simultaneous ack: the data is discarded; go to BUSY on the new PC.
  - DROP: update the target PC and stay in DROP.
- A push never happens when full; the space check precedes every request.
- Empty FIFO: `instr_valid`=0. `instr`/`opcode`/`func`/`pc_out` are don't-care.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC
  - `instr_valid`=0, `instr`=0, `pc_out`=RESET_PC
  - state IDLE, count 0
- First `imem_req` goes high in the first cycle after `reset` deasserts.
- Ack may arrive in the same cycle as req rises (zero-wait memory).
- Push latency: data acked at edge N is visible at the head (`instr_valid`=1) after edge N, i.e. in cycle N+1. There is no bypass.
- Zero-wait memory with the core always ready: sustained 1 instruction/cycle.
- Redirect to first valid instruction: at least 2 cycles (req on the cycle after redirect, ack, push). Add 1 extra ack if in DROP.
- Reset mid-request abandons the transaction. The memory shares `reset`; a stale ack in the reset cycle is ignored.

## Configuration
- `IFETCH_STATS_EN`
  - Defined: adds 32-bit outputs `fetch_cnt` and `flush_cnt`, both reset to 0 and wrapping.
    - `fetch_cnt` increments on every pop.
    - `flush_cnt` increments on every cycle with `redirect`=1.
  - Undefined: ports and logic are absent; behaviour is otherwise identical.

## Test plan
- Reset then zero-wait memory returning `imem_rdata`=addr, core ready: pops PCs 0,4,8,12,... one per cycle; `instr_valid` first high in cycle 2 after reset release.
- Core holds `instr_ready`=0, DEPTH=4: exactly 4 acks accepted, then `imem_req`=0. Assert ready for one cycle: exactly one new request issued, at address 16.
- Memory with 3-cycle ack latency; redirect to 0x104 while BUSY on 0x20: `imem_addr` holds 0x20 until ack, that word is never popped, next request is 0x104, first popped `pc_out`=0x104.
- Redirect coincident with ack and pop, with FIFO holding 2 entries: count becomes 0, acked word dropped, next request at `redirect_pc`; `redirect_pc`=0x207 yields address 0x204.
- Wrap: RESET_PC=0xFFFFFFFC gives fetch addresses 0xFFFFFFFC then 0x00000000.
- Assert `reset` while BUSY with a full FIFO: next cycle `imem_req`=0, `instr_valid`=0, and fetch restarts at RESET_PC. With `IFETCH_STATS_EN` defined, both counters read 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding req/ack memory reads, DEPTH-entry {pc, word} buffer, redirect flush.
// Optional feature macro IFETCH_STATS_EN adds fetch_cnt / flush_cnt counters.
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [10:0]       func,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       flush_cnt
`endif
);
  localparam int               PTR_W = $clog2(DEPTH);
  localparam int               CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;
  state_t state_reg, state_next;

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] stale_addr_reg;
  logic [CNT_W-1:0]  count_reg, count_next, count_step;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [31:0]       word_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic              push, pop;
  logic [ADDR_W-1:0] target_pc;

  assign target_pc   = redirect_pc & ~ADDR_W'(3);
  assign instr_valid = (count_reg != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign push        = (state_reg == BUSY) && imem_ack && !redirect;
  assign count_step  = count_reg + CNT_W'(push) - CNT_W'(pop);
  assign imem_req    = (state_reg != IDLE);
  // DROP keeps presenting the abandoned address until its ack arrives.
  assign imem_addr   = (state_reg == DROP) ? stale_addr_reg : fetch_pc_reg;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    count_next    = redirect ? '0 : count_step;
    if (push)
      fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
    if (redirect)
      fetch_pc_next = target_pc;
    unique case (state_reg)
      IDLE: begin
        if (redirect || count_next < FULL)
          state_next = BUSY;
      end
      BUSY: begin
        if (redirect)
          state_next = imem_ack ? BUSY : DROP;
        else if (imem_ack && count_next >= FULL)
          state_next = IDLE;
      end
      DROP: begin
        if (!redirect && imem_ack)
          state_next = BUSY;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      stale_addr_reg <= RESET_PC;
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      count_reg    <= count_next;
      if (state_reg == BUSY && redirect && !imem_ack)
        stale_addr_reg <= fetch_pc_reg;
      if (redirect) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push)
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]   <= fetch_pc_reg;
    end
  end

  // Head is masked while empty so reset/empty outputs are deterministic.
  assign instr  = instr_valid ? word_mem[rd_ptr_reg] : '0;
  assign pc_out = instr_valid ? pc_mem[rd_ptr_reg] : RESET_PC;
  assign opcode = instr[31:26];
  assign func   = instr[10:0];

`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (pop)
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (redirect)
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif
endmodule
